// File: rtl/block_ram_pkg.sv
// Shared definitions for the simple-dual-port block RAM and its clear sequencer.
package block_ram_pkg;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } clr_state_e;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 2;

   // Number of byte lanes in a word of the given width.
   function automatic int nb(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/block_ram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, writing zero.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_CLEAR | counter walks 0..DEPTH-1, one zero write per cycle, busy=1
//   S_RUN   | idle, array owned by the external ports, busy=0
module block_ram_clear_seq
   import block_ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 14,
   parameter int CLEAR_ON_RESET = 0
) (
   input  logic                  clka,
   input  logic                  rst,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  busy
);

   // One extra counter bit keeps the terminal compare from aliasing with 0.
   localparam logic [ADDR_WIDTH:0] CNT_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam clr_state_e          RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

   clr_state_e          state_q, state_d;
   logic [ADDR_WIDTH:0] cnt_q, cnt_d;

   // State and counter registers; reset always restarts the walk at address 0.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: leave S_CLEAR on the edge that writes the last address.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   assign clr_addr = cnt_q[ADDR_WIDTH-1:0];
   assign busy     = (state_q == S_CLEAR);

endmodule

// File: rtl/block_ram_sdp_v2.sv
// Simple-dual-port block RAM: byte-enabled write port, read port with
// read-enable/valid, per-byte write-first bypass and 1- or 2-cycle latency.
module block_ram_sdp_v2
   import block_ram_pkg::*;
#(
   parameter int    ADDR_WIDTH     = 14,
   parameter int    DATA_WIDTH     = 32,
   parameter int    READ_LATENCY   = 1,
   parameter string INIT_FILE      = "",
   parameter int    CLEAR_ON_RESET = 0
) (
   input  logic                        clka,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       addra,
   input  logic [DATA_WIDTH-1:0]       dina,
   input  logic [nb(DATA_WIDTH)-1:0]   wea,
   input  logic                        rd_en,
   input  logic [ADDR_WIDTH-1:0]       addrb,
   output logic [DATA_WIDTH-1:0]       doutb,
   output logic                        rd_valid,
   output logic                        busy
);

   localparam int NB    = nb(DATA_WIDTH);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
      $error("block_ram_sdp_v2: READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("block_ram_sdp_v2: DATA_WIDTH must be a multiple of 8");
   end

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [NB-1:0]         we_eff;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] ram_rd;
   logic [DATA_WIDTH-1:0] merged;

   block_ram_clear_seq #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clka     (clka),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (busy)
   );

   // While clearing, the sequencer owns the write port and external traffic is dropped.
   always_comb begin
      we_eff = wea;
      waddr  = addra;
      wdata  = dina;
      if (busy) begin
         we_eff = {NB{clr_we}};
         waddr  = clr_addr;
         wdata  = '0;
      end
   end

   assign rd_fire = rd_en & ~busy;

   for (genvar i = 0; i < NB; i++) begin : g_lane
      (* ram_style = "block" *) logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      // Byte-lane array port: read-before-write here, collisions fixed up by the bypass.
      always_ff @(posedge clka) begin
         if (we_eff[i]) begin
            mem[waddr] <= wdata[8*i +: 8];
         end
         if (rd_fire) begin
            rd_q <= mem[addrb];
         end
      end

      assign ram_rd[8*i +: 8] = rd_q;
   end

   logic [NB-1:0]         byp_q, byp_d;
   logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
   logic                  v1_q, v1_d;

   // Capture which lanes of the read collide with a same-edge write, and their new data.
   always_comb begin
      byp_d      = byp_q;
      byp_data_d = byp_data_q;
      v1_d       = rd_fire;
      if (rd_fire) begin
         byp_d      = (addra == addrb) ? wea : '0;
         byp_data_d = dina;
      end
   end

   // First pipeline stage: valid flag and collision information.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         byp_q      <= '0;
         byp_data_q <= '0;
         v1_q       <= 1'b0;
      end else begin
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
         v1_q       <= v1_d;
      end
   end

   // Write-first merge: colliding lanes return the freshly written byte.
   always_comb begin
      merged = ram_rd;
      for (int i = 0; i < NB; i++) begin
         if (byp_q[i]) begin
            merged[8*i +: 8] = byp_data_q[8*i +: 8];
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q, v2_d;
      logic [DATA_WIDTH-1:0] dout2_q, dout2_d;

      // Output stage loads only on a new result, so it holds otherwise.
      always_comb begin
         v2_d    = v1_q;
         dout2_d = v1_q ? merged : dout2_q;
      end

      // Registered output stage.
      always_ff @(posedge clka or posedge rst) begin
         if (rst) begin
            v2_q    <= 1'b0;
            dout2_q <= '0;
         end else begin
            v2_q    <= v2_d;
            dout2_q <= dout2_d;
         end
      end

      assign doutb    = dout2_q;
      assign rd_valid = v2_q;
   end else begin : g_lat1
      logic have_q, have_d;

      // The array read register is not reset; this flag forces doutb to 0 until
      // the first read after reset lands.
      always_comb begin
         have_d = have_q | rd_fire;
      end

      // Tracks whether the read register holds a result from after the last reset.
      always_ff @(posedge clka or posedge rst) begin
         if (rst) begin
            have_q <= 1'b0;
         end else begin
            have_q <= have_d;
         end
      end

      assign doutb    = have_q ? merged : '0;
      assign rd_valid = v1_q;
   end

endmodule

// File: tb/tb_block_ram_sdp_v2.sv
module tb_block_ram_sdp_v2;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst2, rst3;
   logic [13:0] addra, addrb;
   logic [31:0] dina;
   logic [3:0]  wea1, wea2, wea3;
   logic        rd1, rd2, rd3;
   logic [31:0] dout1, dout2, dout3;
   logic        v1, v2, v3, b1, b2, b3;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   exp_t        sq [3][$];
   logic [31:0] m1 [0:16383];
   logic [31:0] m2 [0:63];
   logic [31:0] m3 [0:15];

   logic [31:0] dout_a [3];
   logic        val_a  [3];
   assign dout_a[0] = dout1;
   assign dout_a[1] = dout2;
   assign dout_a[2] = dout3;
   assign val_a[0]  = v1;
   assign val_a[1]  = v2;
   assign val_a[2]  = v3;

   block_ram_sdp_v2 #(
      .ADDR_WIDTH(14), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_FILE(""), .CLEAR_ON_RESET(0)
   ) dut1 (
      .clka(clk), .rst(rst1), .addra(addra), .dina(dina), .wea(wea1), .rd_en(rd1),
      .addrb(addrb), .doutb(dout1), .rd_valid(v1), .busy(b1)
   );

   block_ram_sdp_v2 #(
      .ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(2), .INIT_FILE(""), .CLEAR_ON_RESET(0)
   ) dut2 (
      .clka(clk), .rst(rst2), .addra(addra[5:0]), .dina(dina), .wea(wea2), .rd_en(rd2),
      .addrb(addrb[5:0]), .doutb(dout2), .rd_valid(v2), .busy(b2)
   );

   block_ram_sdp_v2 #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_FILE(""), .CLEAR_ON_RESET(1)
   ) dut3 (
      .clka(clk), .rst(rst3), .addra(addra[3:0]), .dina(dina), .wea(wea3), .rd_en(rd3),
      .addrb(addrb[3:0]), .doutb(dout3), .rd_valid(v3), .busy(b3)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every rd_valid must match the oldest expected result, on its due cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (val_a[d] === 1'b1) begin
            checks++;
            if (sq[d].size() == 0) begin
               failures++;
               $display("FAIL dut%0d_unexpected_valid: got rd_valid=1 doutb=%h at cycle %0d, required no result",
                        d + 1, dout_a[d], cyc);
            end else begin
               e = sq[d].pop_front();
               if (dout_a[d] !== e.data || cyc != e.due) begin
                  failures++;
                  $display("FAIL dut%0d_read: got doutb=%h at cycle %0d, required %h at cycle %0d",
                           d + 1, dout_a[d], cyc, e.data, e.due);
               end
            end
         end else if (sq[d].size() != 0 && sq[d][0].due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_missing_valid: got rd_valid=%b at cycle %0d, required result %h",
                     d + 1, val_a[d], cyc, sq[d][0].data);
            void'(sq[d].pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         wea1 = '0; wea2 = '0; wea3 = '0;
         rd1 = 1'b0; rd2 = 1'b0; rd3 = 1'b0;
      end
   endtask

   // Drive one cycle of write/read on DUT index d and record the expected read result.
   task automatic cyc_op(input int d, input logic [13:0] wa, input logic [31:0] wd,
                         input logic [3:0] we, input logic re, input logic [13:0] ra);
      logic [31:0] old_w, ex, cur;
      int          lat;
      @(posedge clk); #1;
      addra = wa; dina = wd; addrb = ra;
      wea1 = (d == 0) ? we : 4'h0;
      wea2 = (d == 1) ? we : 4'h0;
      wea3 = (d == 2) ? we : 4'h0;
      rd1  = (d == 0) ? re : 1'b0;
      rd2  = (d == 1) ? re : 1'b0;
      rd3  = (d == 2) ? re : 1'b0;
      lat  = (d == 1) ? 2 : 1;
      case (d)
         0:       begin old_w = m1[ra];      cur = m1[wa];      end
         1:       begin old_w = m2[ra[5:0]]; cur = m2[wa[5:0]]; end
         default: begin old_w = m3[ra[3:0]]; cur = m3[wa[3:0]]; end
      endcase
      ex = old_w;
      for (int i = 0; i < 4; i++) begin
         if (we[i] && wa == ra) ex[8*i +: 8] = wd[8*i +: 8];
         if (we[i]) cur[8*i +: 8] = wd[8*i +: 8];
      end
      case (d)
         0:       m1[wa]      = cur;
         1:       m2[wa[5:0]] = cur;
         default: m3[wa[3:0]] = cur;
      endcase
      if (re) sq[d].push_back('{ex, cyc + lat});
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 9;
      if (dout1 !== 32'h0) begin failures++; $display("FAIL reset_dout1: got %h, required 0", dout1); end
      if (v1 !== 1'b0)     begin failures++; $display("FAIL reset_valid1: got %b, required 0", v1); end
      if (b1 !== 1'b0)     begin failures++; $display("FAIL reset_busy1: got %b, required 0", b1); end
      if (dout2 !== 32'h0) begin failures++; $display("FAIL reset_dout2: got %h, required 0", dout2); end
      if (v2 !== 1'b0)     begin failures++; $display("FAIL reset_valid2: got %b, required 0", v2); end
      if (b2 !== 1'b0)     begin failures++; $display("FAIL reset_busy2: got %b, required 0", b2); end
      if (dout3 !== 32'h0) begin failures++; $display("FAIL reset_dout3: got %h, required 0", dout3); end
      if (v3 !== 1'b0)     begin failures++; $display("FAIL reset_valid3: got %b, required 0", v3); end
      if (b3 !== 1'b1)     begin failures++; $display("FAIL reset_busy3: got %b, required 1", b3); end
      @(posedge clk); #1;
      rst1 = 1'b0; rst2 = 1'b0;
   endtask

   task automatic test_basic();
      cyc_op(0, 14'h010, 32'hDEADBEEF, 4'hF, 1'b0, 14'h0);
      cyc_op(0, 14'h0, 32'h0, 4'h0, 1'b1, 14'h010);
      idle(2);
      checks++;
      if (dout1 !== 32'hDEADBEEF || v1 !== 1'b0) begin
         failures++;
         $display("FAIL basic_hold: got doutb=%h rd_valid=%b, required DEADBEEF/0", dout1, v1);
      end
   endtask

   task automatic test_byte_lanes();
      cyc_op(0, 14'd5, 32'h11223344, 4'hF, 1'b0, 14'h0);
      cyc_op(0, 14'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 14'h0);
      cyc_op(0, 14'h0, 32'h0, 4'h0, 1'b1, 14'd5);
      idle(2);
      checks++;
      if (dout1 !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL byte_lanes: got %h, required 11BB33DD", dout1);
      end
   endtask

   task automatic test_collision();
      cyc_op(0, 14'd7, 32'h00000000, 4'hF, 1'b0, 14'h0);
      cyc_op(0, 14'd7, 32'hCAFEF00D, 4'b0011, 1'b1, 14'd7);
      idle(2);
      checks++;
      if (dout1 !== 32'h0000F00D || v1 !== 1'b0) begin
         failures++;
         $display("FAIL collision: got doutb=%h rd_valid=%b, required 0000F00D/0", dout1, v1);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) cyc_op(0, 14'h100 + 14'(i), $urandom, 4'hF, 1'b0, 14'h0);
      for (int i = 0; i < 4; i++) cyc_op(0, 14'h0, 32'h0, 4'h0, 1'b1, 14'h103 - 14'(i));
      cyc_op(0, 14'h101, 32'h5555AAAA, 4'b1001, 1'b1, 14'h101);
      cyc_op(0, 14'h0, 32'h0, 4'h0, 1'b1, 14'h101);
      idle(3);
   endtask

   task automatic test_latency2();
      cyc_op(1, 14'd5, 32'h01020304, 4'hF, 1'b0, 14'h0);
      for (int i = 1; i <= 3; i++) cyc_op(1, 14'(i), $urandom, 4'hF, 1'b0, 14'h0);
      cyc_op(1, 14'h0, 32'h0, 4'h0, 1'b1, 14'd1);
      cyc_op(1, 14'd1, 32'h77777777, 4'hF, 1'b1, 14'd2);
      cyc_op(1, 14'h0, 32'h0, 4'h0, 1'b1, 14'd3);
      cyc_op(1, 14'd5, 32'hF0E0D0C0, 4'b1100, 1'b1, 14'd5);
      cyc_op(1, 14'h0, 32'h0, 4'h0, 1'b1, 14'd1);
      idle(4);
      checks++;
      if (dout2 !== 32'h77777777 || v2 !== 1'b0) begin
         failures++;
         $display("FAIL lat2_hold: got doutb=%h rd_valid=%b, required 77777777/0", dout2, v2);
      end
   endtask

   task automatic test_reset_mid_read();
      cyc_op(0, 14'h0, 32'h0, 4'h0, 1'b1, 14'h010);
      @(posedge clk); #1;
      rd1 = 1'b0; rst1 = 1'b1;
      sq[0].delete();
      #1;
      checks += 2;
      if (dout1 !== 32'h0) begin failures++; $display("FAIL midread_dout: got %h, required 0", dout1); end
      if (v1 !== 1'b0)     begin failures++; $display("FAIL midread_valid: got %b, required 0", v1); end
      @(posedge clk); #1;
      rst1 = 1'b0;
      idle(4);
      checks++;
      if (dout1 !== 32'h0) begin
         failures++;
         $display("FAIL midread_after_release: got %h, required 0", dout1);
      end
   endtask

   task automatic test_clear();
      // First clear run with conflicting traffic that must be dropped.
      @(posedge clk); #1;
      rst3 = 1'b0; addra = 14'h0; dina = 32'hFFFFFFFF; wea3 = 4'hF; rd3 = 1'b1; addrb = 14'd3;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (b3 !== 1'b1) begin failures++; $display("FAIL clear_busy_%0d: got %b, required 1", k, b3); end
         @(posedge clk); #1;
      end
      wea3 = 4'h0; rd3 = 1'b0;
      checks++;
      if (b3 !== 1'b0) begin failures++; $display("FAIL clear_done: got busy=%b, required 0", b3); end
      cyc_op(2, 14'h0, 32'h0, 4'h0, 1'b1, 14'd0);
      // Fill with nonzero data, then reset and pulse reset again mid-clear.
      for (int a = 0; a < 16; a++) cyc_op(2, 14'(a), 32'h5A5A0000 | 32'(a + 1), 4'hF, 1'b0, 14'h0);
      cyc_op(2, 14'h0, 32'h0, 4'h0, 1'b1, 14'd9);
      idle(3);
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (b3 !== 1'b1) begin failures++; $display("FAIL reclear_busy_%0d: got %b, required 1", k, b3); end
         @(posedge clk); #1;
      end
      checks++;
      if (b3 !== 1'b0) begin failures++; $display("FAIL reclear_done: got busy=%b, required 0", b3); end
      for (int a = 0; a < 16; a++) m3[a] = 32'h0;
      for (int a = 0; a < 16; a++) cyc_op(2, 14'h0, 32'h0, 4'h0, 1'b1, 14'(a));
      idle(3);
   endtask

   initial begin
      rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
      addra = '0; addrb = '0; dina = '0;
      wea1 = '0; wea2 = '0; wea3 = '0;
      rd1 = 1'b0; rd2 = 1'b0; rd3 = 1'b0;
      for (int a = 0; a < 16384; a++) m1[a] = 32'h0;
      for (int a = 0; a < 64; a++)    m2[a] = 32'h0;
      for (int a = 0; a < 16; a++)    m3[a] = 32'h0;
      test_reset();
      test_basic();
      test_byte_lanes();
      test_collision();
      test_back_to_back();
      test_latency2();
      test_reset_mid_read();
      test_clear();
      idle(4);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (sq[d].size() != 0) begin
            failures++;
            $display("FAIL dut%0d_drain: got %0d outstanding results, required 0", d + 1, sq[d].size());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
